// File: rtl/ex_mem_stage.sv
// ----------------------------------------------------------------------------
// ExMemStage : EX/MEM pipeline register with a two-entry skid buffer
//
// Purpose
//    Holds up to two execute-stage results between the ALU and the memory
//    stage. The main entry (M) drives the out_* ports; the skid entry (S)
//    absorbs one extra result so that in_ready can come straight from a flop.
//    The branch decision is resolved when an entry is accepted and travels
//    with it. Two free-running counters track retired entries and retired
//    taken branches.
//
// Ports
//    clk, rst_n        clock, synchronous active-low reset
//    in_valid/in_ready upstream handshake (in_ready is a flop output)
//    alu_res, alu_*    ALU result and flags (carry = bit 32 of A+B / A-B)
//    store_data, rd, reg_write, is_load, is_store, is_branch, funct3,
//    br_target_in      instruction side-band captured with the entry
//    flush             drop every held entry and any same-cycle accept
//    out_valid/out_ready downstream handshake
//    out_*             main-entry fields, forced to 0 while out_valid=0
//    br_taken, br_target branch outcome of the main entry
//    retired_cnt, taken_cnt  wrapping transfer counters
// ----------------------------------------------------------------------------
module ex_mem_stage (
   input  logic        clk,
   input  logic        rst_n,
   input  logic        in_valid,
   output logic        in_ready,
   input  logic [31:0] alu_res,
   input  logic        alu_neg,
   input  logic        alu_carry,
   input  logic        alu_overflow,
   input  logic        alu_zero,
   input  logic [31:0] store_data,
   input  logic [4:0]  rd,
   input  logic        reg_write,
   input  logic        is_load,
   input  logic        is_store,
   input  logic        is_branch,
   input  logic [2:0]  funct3,
   input  logic [31:0] br_target_in,
   input  logic        flush,
   output logic        out_valid,
   input  logic        out_ready,
   output logic [31:0] out_res,
   output logic [31:0] out_store_data,
   output logic [4:0]  out_rd,
   output logic        out_reg_write,
   output logic        out_is_load,
   output logic        out_is_store,
   output logic        out_illegal,
   output logic        br_taken,
   output logic [31:0] br_target,
   output logic [31:0] retired_cnt,
   output logic [31:0] taken_cnt
);

   typedef enum logic [1:0] {
      EMPTY = 2'd0,
      ONE   = 2'd1,
      FULL  = 2'd2
   } state_t;

   typedef struct packed {
      logic [31:0] res;
      logic [31:0] storeData;
      logic [4:0]  rd;
      logic        regWrite;
      logic        isLoad;
      logic        isStore;
      logic        taken;
      logic        illegal;
      logic [31:0] target;
   } entry_t;

   state_t      r_state;
   state_t      w_nextState;
   logic        r_inReady;
   entry_t      r_main;
   entry_t      r_skid;
   entry_t      w_inEntry;
   logic [31:0] r_retiredCnt;
   logic [31:0] r_takenCnt;

   logic        w_mainValid;
   logic        w_accept;
   logic        w_transfer;
   logic        w_brTaken;
   logic        w_loadMain;
   logic        w_loadSkid;
   logic        w_moveSkid;
   logic        w_taken;
   logic        w_illegal;

   // M is valid in ONE and FULL; a flush turns any accept into a no-op so the
   // incoming entry is simply never written anywhere.
   assign w_mainValid = (r_state != EMPTY);
   assign w_accept    = in_valid & r_inReady & ~flush;
   assign w_transfer  = w_mainValid & out_ready;
   assign w_brTaken   = w_mainValid & r_main.taken;

   // Branch resolution from the ALU flags of the incoming instruction.
   // funct3 010/011 are not branch encodings, so they are marked illegal and
   // never taken; non-branches ignore funct3 entirely.
   always_comb begin
      w_taken   = 1'b0;
      w_illegal = 1'b0;
      if (is_branch) begin
         case (funct3)
            3'b000:  w_taken = alu_zero;
            3'b001:  w_taken = ~alu_zero;
            3'b100:  w_taken = alu_neg ^ alu_overflow;
            3'b101:  w_taken = ~(alu_neg ^ alu_overflow);
            3'b110:  w_taken = alu_carry;
            3'b111:  w_taken = ~alu_carry;
            default: w_illegal = 1'b1;
         endcase
      end
   end

   // Bundle the incoming instruction into the entry format stored in M/S.
   always_comb begin
      w_inEntry           = '0;
      w_inEntry.res       = alu_res;
      w_inEntry.storeData = store_data;
      w_inEntry.rd        = rd;
      w_inEntry.regWrite  = reg_write;
      w_inEntry.isLoad    = is_load;
      w_inEntry.isStore   = is_store;
      w_inEntry.taken     = w_taken;
      w_inEntry.illegal   = w_illegal;
      w_inEntry.target    = br_target_in;
   end

   // Next-state and datapath steering. Accept is impossible in FULL because
   // in_ready is low there, so FULL only ever looks at the transfer.
   always_comb begin
      w_nextState = r_state;
      w_loadMain  = 1'b0;
      w_loadSkid  = 1'b0;
      w_moveSkid  = 1'b0;
      if (flush) begin
         w_nextState = EMPTY;
      end else begin
         case (r_state)
            EMPTY: begin
               if (w_accept) begin
                  w_nextState = ONE;
                  w_loadMain  = 1'b1;
               end
            end
            ONE: begin
               if (w_accept && !w_transfer) begin
                  w_nextState = FULL;
                  w_loadSkid  = 1'b1;
               end else if (w_accept && w_transfer) begin
                  w_nextState = ONE;
                  w_loadMain  = 1'b1;
               end else if (w_transfer) begin
                  w_nextState = EMPTY;
               end
            end
            FULL: begin
               if (w_transfer) begin
                  w_nextState = ONE;
                  w_moveSkid  = 1'b1;
               end
            end
            default: w_nextState = EMPTY;
         endcase
      end
   end

   // Control state, the registered in_ready and the counters. in_ready is the
   // next-cycle "skid empty" flag, so it drops only when heading into FULL.
   // Transfers in a flush cycle still retire and are counted.
   always_ff @(posedge clk) begin
      if (!rst_n) begin
         r_state      <= EMPTY;
         r_inReady    <= 1'b1;
         r_retiredCnt <= '0;
         r_takenCnt   <= '0;
      end else begin
         r_state   <= w_nextState;
         r_inReady <= (w_nextState != FULL);
         if (w_transfer) begin
            r_retiredCnt <= r_retiredCnt + 32'd1;
            if (w_brTaken) begin
               r_takenCnt <= r_takenCnt + 32'd1;
            end
         end
      end
   end

   // Entry payloads need no reset: every observer is gated by the valid state.
   always_ff @(posedge clk) begin
      if (w_loadMain) begin
         r_main <= w_inEntry;
      end else if (w_moveSkid) begin
         r_main <= r_skid;
      end
      if (w_loadSkid) begin
         r_skid <= w_inEntry;
      end
   end

   // Output data is zeroed when no entry is presented so downstream never
   // sees stale payloads.
   assign in_ready       = r_inReady;
   assign out_valid      = w_mainValid;
   assign out_res        = w_mainValid ? r_main.res       : 32'd0;
   assign out_store_data = w_mainValid ? r_main.storeData : 32'd0;
   assign out_rd         = w_mainValid ? r_main.rd        : 5'd0;
   assign out_reg_write  = w_mainValid & r_main.regWrite;
   assign out_is_load    = w_mainValid & r_main.isLoad;
   assign out_is_store   = w_mainValid & r_main.isStore;
   assign out_illegal    = w_mainValid & r_main.illegal;
   assign br_taken       = w_brTaken;
   assign br_target      = w_mainValid ? r_main.target    : 32'd0;
   assign retired_cnt    = r_retiredCnt;
   assign taken_cnt      = r_takenCnt;

endmodule

// File: tb/tb_ex_mem_stage.sv
// ----------------------------------------------------------------------------
// TbExMemStage : directed testbench for ex_mem_stage
//
// Each feature has its own task that drives vectors and compares the DUT
// outputs against hand-computed values. Inputs change 1 ns after a rising
// edge and outputs are sampled at that same point, so every observation
// reflects the state registered at the preceding edge.
// ----------------------------------------------------------------------------
module tb_ex_mem_stage;

   logic        clk = 1'b0;
   logic        rst_n;
   logic        in_valid;
   logic        in_ready;
   logic [31:0] alu_res;
   logic        alu_neg;
   logic        alu_carry;
   logic        alu_overflow;
   logic        alu_zero;
   logic [31:0] store_data;
   logic [4:0]  rd;
   logic        reg_write;
   logic        is_load;
   logic        is_store;
   logic        is_branch;
   logic [2:0]  funct3;
   logic [31:0] br_target_in;
   logic        flush;
   logic        out_valid;
   logic        out_ready;
   logic [31:0] out_res;
   logic [31:0] out_store_data;
   logic [4:0]  out_rd;
   logic        out_reg_write;
   logic        out_is_load;
   logic        out_is_store;
   logic        out_illegal;
   logic        br_taken;
   logic [31:0] br_target;
   logic [31:0] retired_cnt;
   logic [31:0] taken_cnt;

   int          nChecks = 0;
   int          nPass   = 0;
   logic [31:0] expRetired;
   logic [31:0] expTaken;

   // Branch vectors: {isBranch, funct3[2:0], zero, neg, ovf, carry,
   //                  expectedTaken, expectedIllegal}
   localparam logic [9:0] BR_VEC [0:13] = '{
      10'b1_000_1000_10,   // BEQ  zero=1          -> taken
      10'b1_000_0000_00,   // BEQ  zero=0          -> not taken
      10'b1_001_1000_00,   // BNE  zero=1          -> not taken
      10'b1_100_0100_10,   // BLT  neg=1 ovf=0     -> taken
      10'b1_100_0110_00,   // BLT  neg=1 ovf=1     -> not taken
      10'b1_101_0110_10,   // BGE  neg=1 ovf=1     -> taken
      10'b1_101_0100_00,   // BGE  neg=1 ovf=0     -> not taken
      10'b1_110_0001_10,   // BLTU carry=1         -> taken
      10'b1_111_0000_10,   // BGEU carry=0         -> taken
      10'b1_111_0001_00,   // BGEU carry=1         -> not taken
      10'b1_010_1001_01,   // funct3 010           -> illegal
      10'b1_011_0000_01,   // funct3 011           -> illegal
      10'b0_000_1000_00,   // not a branch         -> ignored
      10'b1_001_0000_10    // BNE  zero=0          -> taken
   };

   ex_mem_stage dut (
      .clk            (clk),
      .rst_n          (rst_n),
      .in_valid       (in_valid),
      .in_ready       (in_ready),
      .alu_res        (alu_res),
      .alu_neg        (alu_neg),
      .alu_carry      (alu_carry),
      .alu_overflow   (alu_overflow),
      .alu_zero       (alu_zero),
      .store_data     (store_data),
      .rd             (rd),
      .reg_write      (reg_write),
      .is_load        (is_load),
      .is_store       (is_store),
      .is_branch      (is_branch),
      .funct3         (funct3),
      .br_target_in   (br_target_in),
      .flush          (flush),
      .out_valid      (out_valid),
      .out_ready      (out_ready),
      .out_res        (out_res),
      .out_store_data (out_store_data),
      .out_rd         (out_rd),
      .out_reg_write  (out_reg_write),
      .out_is_load    (out_is_load),
      .out_is_store   (out_is_store),
      .out_illegal    (out_illegal),
      .br_taken       (br_taken),
      .br_target      (br_target),
      .retired_cnt    (retired_cnt),
      .taken_cnt      (taken_cnt)
   );

   // 10 ns clock
   always #5 clk = ~clk;

   task automatic tick;
      @(posedge clk);
      #1;
   endtask

   task automatic idleInputs;
      in_valid     = 1'b0;
      alu_res      = '0;
      alu_neg      = 1'b0;
      alu_carry    = 1'b0;
      alu_overflow = 1'b0;
      alu_zero     = 1'b0;
      store_data   = '0;
      rd           = '0;
      reg_write    = 1'b0;
      is_load      = 1'b0;
      is_store     = 1'b0;
      is_branch    = 1'b0;
      funct3       = '0;
      br_target_in = '0;
      flush        = 1'b0;
   endtask

   // Present one instruction; store_data is the complement of the result.
   task automatic driveEntry(input logic [31:0] res, input logic [4:0] rdIn,
                             input logic isBr, input logic [2:0] f3,
                             input logic zero, input logic neg,
                             input logic ovf, input logic carry,
                             input logic [31:0] tgt);
      in_valid     = 1'b1;
      alu_res      = res;
      store_data   = ~res;
      rd           = rdIn;
      reg_write    = 1'b1;
      is_load      = 1'b0;
      is_store     = 1'b0;
      is_branch    = isBr;
      funct3       = f3;
      alu_zero     = zero;
      alu_neg      = neg;
      alu_overflow = ovf;
      alu_carry    = carry;
      br_target_in = tgt;
   endtask

   // Reset with in_valid and flush both high; everything must come up idle.
   task automatic test_reset;
      rst_n     = 1'b0;
      out_ready = 1'b1;
      idleInputs();
      driveEntry(32'hDEADBEEF, 5'd3, 1'b1, 3'b000, 1'b1, 1'b0, 1'b0, 1'b0, 32'h44);
      flush = 1'b1;
      tick();
      tick();
      nChecks++; if (out_valid !== 1'b0) $display("[TB] FAIL reset_out_valid: got %0h expected 0", out_valid); else nPass++;
      nChecks++; if (in_ready !== 1'b1) $display("[TB] FAIL reset_in_ready: got %0h expected 1", in_ready); else nPass++;
      nChecks++; if (br_taken !== 1'b0) $display("[TB] FAIL reset_br_taken: got %0h expected 0", br_taken); else nPass++;
      nChecks++; if (out_res !== 32'd0) $display("[TB] FAIL reset_out_res: got %0h expected 0", out_res); else nPass++;
      nChecks++; if (br_target !== 32'd0) $display("[TB] FAIL reset_br_target: got %0h expected 0", br_target); else nPass++;
      nChecks++; if (retired_cnt !== 32'd0) $display("[TB] FAIL reset_retired: got %0h expected 0", retired_cnt); else nPass++;
      nChecks++; if (taken_cnt !== 32'd0) $display("[TB] FAIL reset_taken: got %0h expected 0", taken_cnt); else nPass++;
      rst_n = 1'b1;
      idleInputs();
      tick();
      nChecks++; if (out_valid !== 1'b0) $display("[TB] FAIL reset_ignored_accept: got %0h expected 0", out_valid); else nPass++;
      expRetired = 32'd0;
      expTaken   = 32'd0;
   endtask

   task automatic test_passthrough;
      out_ready = 1'b1;
      driveEntry(32'h12345678, 5'd5, 1'b0, 3'b000, 1'b0, 1'b0, 1'b0, 1'b0, 32'h0);
      tick();
      idleInputs();
      nChecks++; if (out_valid !== 1'b1) $display("[TB] FAIL pass_valid: got %0h expected 1", out_valid); else nPass++;
      nChecks++; if (out_res !== 32'h12345678) $display("[TB] FAIL pass_res: got %0h expected 12345678", out_res); else nPass++;
      nChecks++; if (out_store_data !== 32'hEDCBA987) $display("[TB] FAIL pass_store_data: got %0h expected edcba987", out_store_data); else nPass++;
      nChecks++; if (out_rd !== 5'd5) $display("[TB] FAIL pass_rd: got %0d expected 5", out_rd); else nPass++;
      nChecks++; if (out_reg_write !== 1'b1) $display("[TB] FAIL pass_reg_write: got %0h expected 1", out_reg_write); else nPass++;
      nChecks++; if (retired_cnt !== 32'd0) $display("[TB] FAIL pass_retired_before: got %0h expected 0", retired_cnt); else nPass++;
      tick();
      expRetired = 32'd1;
      nChecks++; if (retired_cnt !== expRetired) $display("[TB] FAIL pass_retired_after: got %0h expected %0h", retired_cnt, expRetired); else nPass++;
      nChecks++; if (out_valid !== 1'b0) $display("[TB] FAIL pass_drained: got %0h expected 0", out_valid); else nPass++;
      nChecks++; if (out_res !== 32'd0) $display("[TB] FAIL pass_res_zeroed: got %0h expected 0", out_res); else nPass++;
   endtask

   task automatic test_backpressure;
      out_ready = 1'b0;
      driveEntry(32'hA0A0A0A0, 5'd1, 1'b0, 3'b000, 1'b0, 1'b0, 1'b0, 1'b0, 32'h0);
      tick();
      nChecks++; if (in_ready !== 1'b1) $display("[TB] FAIL bp_ready_one: got %0h expected 1", in_ready); else nPass++;
      driveEntry(32'hB1B1B1B1, 5'd2, 1'b0, 3'b000, 1'b0, 1'b0, 1'b0, 1'b0, 32'h0);
      tick();
      nChecks++; if (in_ready !== 1'b0) $display("[TB] FAIL bp_ready_full: got %0h expected 0", in_ready); else nPass++;
      driveEntry(32'hC2C2C2C2, 5'd3, 1'b0, 3'b000, 1'b0, 1'b0, 1'b0, 1'b0, 32'h0);
      tick();
      nChecks++; if (out_res !== 32'hA0A0A0A0) $display("[TB] FAIL bp_hold_res: got %0h expected a0a0a0a0", out_res); else nPass++;
      nChecks++; if (out_rd !== 5'd1) $display("[TB] FAIL bp_hold_rd: got %0d expected 1", out_rd); else nPass++;
      nChecks++; if (in_ready !== 1'b0) $display("[TB] FAIL bp_ready_still_low: got %0h expected 0", in_ready); else nPass++;
      idleInputs();
      out_ready = 1'b1;
      tick();
      expRetired = expRetired + 32'd1;
      nChecks++; if (out_res !== 32'hB1B1B1B1) $display("[TB] FAIL bp_second_res: got %0h expected b1b1b1b1", out_res); else nPass++;
      nChecks++; if (in_ready !== 1'b1) $display("[TB] FAIL bp_ready_back: got %0h expected 1", in_ready); else nPass++;
      nChecks++; if (retired_cnt !== expRetired) $display("[TB] FAIL bp_retired_1: got %0h expected %0h", retired_cnt, expRetired); else nPass++;
      tick();
      expRetired = expRetired + 32'd1;
      nChecks++; if (out_valid !== 1'b0) $display("[TB] FAIL bp_empty: got %0h expected 0", out_valid); else nPass++;
      nChecks++; if (retired_cnt !== expRetired) $display("[TB] FAIL bp_retired_2: got %0h expected %0h", retired_cnt, expRetired); else nPass++;
      tick();
      nChecks++; if (out_valid !== 1'b0) $display("[TB] FAIL bp_third_dropped: got %0h expected 0", out_valid); else nPass++;
   endtask

   // Entries stream back-to-back with out_ready=1, so entry i is observed
   // while entry i-1 has just retired.
   task automatic test_branch;
      logic [9:0]  v;
      logic [31:0] tgt;
      out_ready = 1'b1;
      for (int i = 0; i < 14; i++) begin
         v   = BR_VEC[i];
         tgt = 32'h1000 + 32'(i) * 32'd4;
         driveEntry(32'h100 + 32'(i), 5'(i), v[9], v[8:6], v[5], v[4], v[3], v[2], tgt);
         tick();
         nChecks++; if (br_taken !== v[1]) $display("[TB] FAIL br_taken_%0d: got %0h expected %0h", i, br_taken, v[1]); else nPass++;
         nChecks++; if (out_illegal !== v[0]) $display("[TB] FAIL br_illegal_%0d: got %0h expected %0h", i, out_illegal, v[0]); else nPass++;
         nChecks++; if (br_target !== tgt) $display("[TB] FAIL br_target_%0d: got %0h expected %0h", i, br_target, tgt); else nPass++;
         nChecks++; if (taken_cnt !== expTaken) $display("[TB] FAIL br_taken_cnt_%0d: got %0h expected %0h", i, taken_cnt, expTaken); else nPass++;
         if (v[1]) expTaken = expTaken + 32'd1;
         expRetired = expRetired + 32'd1;
      end
      idleInputs();
      tick();
      nChecks++; if (taken_cnt !== 32'd6) $display("[TB] FAIL br_taken_total: got %0h expected 6", taken_cnt); else nPass++;
      nChecks++; if (retired_cnt !== expRetired) $display("[TB] FAIL br_retired_total: got %0h expected %0h", retired_cnt, expRetired); else nPass++;
      nChecks++; if (br_target !== 32'd0) $display("[TB] FAIL br_target_idle: got %0h expected 0", br_target); else nPass++;
   endtask

   task automatic test_flush;
      out_ready = 1'b0;
      driveEntry(32'h11111111, 5'd7, 1'b1, 3'b000, 1'b1, 1'b0, 1'b0, 1'b0, 32'h2000);
      tick();
      driveEntry(32'h22222222, 5'd8, 1'b0, 3'b000, 1'b0, 1'b0, 1'b0, 1'b0, 32'h0);
      tick();
      nChecks++; if (in_ready !== 1'b0) $display("[TB] FAIL flush_full_ready: got %0h expected 0", in_ready); else nPass++;
      driveEntry(32'h33333333, 5'd9, 1'b0, 3'b000, 1'b0, 1'b0, 1'b0, 1'b0, 32'h0);
      flush     = 1'b1;
      out_ready = 1'b1;
      tick();
      expRetired = expRetired + 32'd1;
      expTaken   = expTaken + 32'd1;
      nChecks++; if (out_valid !== 1'b0) $display("[TB] FAIL flush_valid: got %0h expected 0", out_valid); else nPass++;
      nChecks++; if (in_ready !== 1'b1) $display("[TB] FAIL flush_ready: got %0h expected 1", in_ready); else nPass++;
      nChecks++; if (retired_cnt !== expRetired) $display("[TB] FAIL flush_retired: got %0h expected %0h", retired_cnt, expRetired); else nPass++;
      nChecks++; if (taken_cnt !== expTaken) $display("[TB] FAIL flush_taken: got %0h expected %0h", taken_cnt, expTaken); else nPass++;
      idleInputs();
      tick();
      nChecks++; if (out_valid !== 1'b0) $display("[TB] FAIL flush_input_dropped: got %0h expected 0", out_valid); else nPass++;
      // Flush in ONE with a simultaneous accept: the new entry must vanish too.
      out_ready = 1'b0;
      driveEntry(32'h44444444, 5'd10, 1'b0, 3'b000, 1'b0, 1'b0, 1'b0, 1'b0, 32'h0);
      tick();
      driveEntry(32'h55555555, 5'd11, 1'b0, 3'b000, 1'b0, 1'b0, 1'b0, 1'b0, 32'h0);
      flush = 1'b1;
      tick();
      idleInputs();
      nChecks++; if (out_valid !== 1'b0) $display("[TB] FAIL flush_one_valid: got %0h expected 0", out_valid); else nPass++;
      tick();
      nChecks++; if (out_valid !== 1'b0) $display("[TB] FAIL flush_one_accept_dropped: got %0h expected 0", out_valid); else nPass++;
      nChecks++; if (retired_cnt !== expRetired) $display("[TB] FAIL flush_one_retired: got %0h expected %0h", retired_cnt, expRetired); else nPass++;
   endtask

   // Preload both counters to all-ones, then retire one taken branch.
   task automatic test_wrap;
      dut.r_retiredCnt = 32'hFFFFFFFF;
      dut.r_takenCnt   = 32'hFFFFFFFF;
      out_ready = 1'b1;
      driveEntry(32'h66666666, 5'd12, 1'b1, 3'b000, 1'b1, 1'b0, 1'b0, 1'b0, 32'h3000);
      tick();
      idleInputs();
      nChecks++; if (br_taken !== 1'b1) $display("[TB] FAIL wrap_br_taken: got %0h expected 1", br_taken); else nPass++;
      tick();
      nChecks++; if (retired_cnt !== 32'd0) $display("[TB] FAIL wrap_retired: got %0h expected 0", retired_cnt); else nPass++;
      nChecks++; if (taken_cnt !== 32'd0) $display("[TB] FAIL wrap_taken: got %0h expected 0", taken_cnt); else nPass++;
   endtask

   task automatic test_reset_midstream;
      out_ready = 1'b1;
      driveEntry(32'h77777777, 5'd13, 1'b1, 3'b001, 1'b0, 1'b0, 1'b0, 1'b0, 32'h4000);
      tick();
      idleInputs();
      tick();
      nChecks++; if (retired_cnt !== 32'd1) $display("[TB] FAIL rst_mid_pre_retired: got %0h expected 1", retired_cnt); else nPass++;
      out_ready = 1'b0;
      driveEntry(32'h88888888, 5'd14, 1'b0, 3'b000, 1'b0, 1'b0, 1'b0, 1'b0, 32'h0);
      tick();
      driveEntry(32'h99999999, 5'd15, 1'b0, 3'b000, 1'b0, 1'b0, 1'b0, 1'b0, 32'h0);
      tick();
      idleInputs();
      nChecks++; if (in_ready !== 1'b0) $display("[TB] FAIL rst_mid_full: got %0h expected 0", in_ready); else nPass++;
      rst_n     = 1'b0;
      out_ready = 1'b1;
      tick();
      nChecks++; if (out_valid !== 1'b0) $display("[TB] FAIL rst_mid_valid: got %0h expected 0", out_valid); else nPass++;
      nChecks++; if (in_ready !== 1'b1) $display("[TB] FAIL rst_mid_ready: got %0h expected 1", in_ready); else nPass++;
      nChecks++; if (retired_cnt !== 32'd0) $display("[TB] FAIL rst_mid_retired: got %0h expected 0", retired_cnt); else nPass++;
      nChecks++; if (taken_cnt !== 32'd0) $display("[TB] FAIL rst_mid_taken: got %0h expected 0", taken_cnt); else nPass++;
      nChecks++; if (out_res !== 32'd0) $display("[TB] FAIL rst_mid_res: got %0h expected 0", out_res); else nPass++;
      rst_n = 1'b1;
      tick();
      nChecks++; if (out_valid !== 1'b0) $display("[TB] FAIL rst_mid_no_output: got %0h expected 0", out_valid); else nPass++;
      nChecks++; if (retired_cnt !== 32'd0) $display("[TB] FAIL rst_mid_retired_after: got %0h expected 0", retired_cnt); else nPass++;
   endtask

   initial begin
      expRetired = 32'd0;
      expTaken   = 32'd0;
      test_reset();
      test_passthrough();
      test_backpressure();
      test_branch();
      test_flush();
      test_wrap();
      test_reset_midstream();
      $display("%0d/%0d checks passed", nPass, nChecks);
      $finish;
   end

endmodule
